register_scoreboard: RTL and testbench

REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

---
 rtl/register_scoreboard.sv | 134 +++++++++++++
 tb/tb_register_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/register_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : register_scoreboard
// Brief   : Tracks MEM/WB destination registers for forwarding, detects
//           load-use hazards, and runs the data-cache wait FSM. Defining
//           REGISTER_SCOREBOARD_STATS_EN adds a saturating stall_cnt output.
// Revision: 1.0 - initial release
// ============================================================================
module register_scoreboard #(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RegWr_ex,
  input  logic [4:0] RegDst_ex,
  input  logic       MemRead_ex,
  input  logic       MemAcc_ex,
  input  logic       flush_ex,
  input  logic [4:0] Rs_id,
  input  logic [4:0] Rt_id,
  input  logic       ihit,
  input  logic       dhit,
  output logic       RegWr_mem,
  output logic [4:0] RegDst_mem,
  output logic       RegWr_wb,
  output logic [4:0] RegDst_wb,
  output logic       pipe_en,
  output logic       stall_id,
  output logic       mem_wait
`ifdef REGISTER_SCOREBOARD_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  if (STALL_CNT_W < 1) begin : g_bad_width
    $error("STALL_CNT_W must be at least 1");
  end

  logic       regwr_mem_q, regwr_mem_d;
  logic [4:0] regdst_mem_q, regdst_mem_d;
  logic       memacc_mem_q, memacc_mem_d;
  logic       regwr_wb_q, regwr_wb_d;
  logic [4:0] regdst_wb_q, regdst_wb_d;
  logic [0:0] state_q, state_d;

  assign pipe_en  = ihit & (~memacc_mem_q | dhit);
  assign stall_id = MemRead_ex & RegWr_ex & (RegDst_ex != 5'd0) &
                    ((RegDst_ex == Rs_id) | (RegDst_ex == Rt_id));

  always_comb begin
    regwr_mem_d  = regwr_mem_q;
    regdst_mem_d = regdst_mem_q;
    memacc_mem_d = memacc_mem_q;
    regwr_wb_d   = regwr_wb_q;
    regdst_wb_d  = regdst_wb_q;
    if (pipe_en) begin
      regwr_wb_d  = regwr_mem_q;
      regdst_wb_d = regdst_mem_q;
      if (flush_ex) begin
        regwr_mem_d  = 1'b0;
        regdst_mem_d = 5'd0;
        memacc_mem_d = 1'b0;
      end else begin
        regwr_mem_d  = RegWr_ex;
        regdst_mem_d = RegDst_ex;
        memacc_mem_d = MemAcc_ex;
      end
    end else if (memacc_mem_q && dhit) begin
      // Access finished while the I-side stalls: retire it so it is not redone.
      memacc_mem_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (memacc_mem_q && !dhit) state_d = MEM_WAIT;
      MEM_WAIT: if (dhit) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regwr_mem_q  <= 1'b0;
      regdst_mem_q <= 5'd0;
      memacc_mem_q <= 1'b0;
      regwr_wb_q   <= 1'b0;
      regdst_wb_q  <= 5'd0;
      state_q      <= RUN;
    end else begin
      regwr_mem_q  <= regwr_mem_d;
      regdst_mem_q <= regdst_mem_d;
      memacc_mem_q <= memacc_mem_d;
      regwr_wb_q   <= regwr_wb_d;
      regdst_wb_q  <= regdst_wb_d;
      state_q      <= state_d;
    end
  end

  // Writes to $0 are architecturally void, so never advertise them for forwarding.
  assign RegWr_mem  = regwr_mem_q & (regdst_mem_q != 5'd0);
  assign RegDst_mem = regdst_mem_q;
  assign RegWr_wb   = regwr_wb_q & (regdst_wb_q != 5'd0);
  assign RegDst_wb  = regdst_wb_q;
  assign mem_wait   = (state_q == MEM_WAIT);

`ifdef REGISTER_SCOREBOARD_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((!pipe_en || stall_id) && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_register_scoreboard.sv
`default_nettype none
// Testbench for register_scoreboard: directed scenarios plus randomized traffic
// compared against a pipeline-level reference model.
module tb_register_scoreboard;

  localparam int W = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RegWr_ex, MemRead_ex, MemAcc_ex, flush_ex, ihit, dhit;
  logic [4:0] RegDst_ex, Rs_id, Rt_id;
  logic       RegWr_mem, RegWr_wb, pipe_en, stall_id, mem_wait;
  logic [4:0] RegDst_mem, RegDst_wb;
`ifdef REGISTER_SCOREBOARD_STATS_EN
  logic [W-1:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: contents of the MEM and WB stages and outstanding-access flag.
  logic       m_wr, m_acc, w_wr, m_wait;
  logic [4:0] m_dst, w_dst;
  int         m_cnt;

  always #5 CLK = ~CLK;

  register_scoreboard #(.STALL_CNT_W(W)) dut (
    .CLK(CLK), .RST(RST),
    .RegWr_ex(RegWr_ex), .RegDst_ex(RegDst_ex), .MemRead_ex(MemRead_ex),
    .MemAcc_ex(MemAcc_ex), .flush_ex(flush_ex), .Rs_id(Rs_id), .Rt_id(Rt_id),
    .ihit(ihit), .dhit(dhit),
    .RegWr_mem(RegWr_mem), .RegDst_mem(RegDst_mem),
    .RegWr_wb(RegWr_wb), .RegDst_wb(RegDst_wb),
    .pipe_en(pipe_en), .stall_id(stall_id), .mem_wait(mem_wait)
`ifdef REGISTER_SCOREBOARD_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_pipe_en();
    return ihit && (!m_acc || dhit);
  endfunction

  function automatic logic exp_stall();
    return MemRead_ex && RegWr_ex && RegDst_ex != 0 &&
           (RegDst_ex == Rs_id || RegDst_ex == Rt_id);
  endfunction

  task automatic model_clear();
    m_wr = 0; m_acc = 0; w_wr = 0; m_wait = 0; m_dst = 0; w_dst = 0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    check("mem_wr",   RegWr_mem,  m_wr && m_dst != 0);
    check("mem_dst",  RegDst_mem, m_dst);
    check("wb_wr",    RegWr_wb,   w_wr && w_dst != 0);
    check("wb_dst",   RegDst_wb,  w_dst);
    check("pipe_en",  pipe_en,    exp_pipe_en());
    check("stall_id", stall_id,   exp_stall());
    check("mem_wait", mem_wait,   m_wait);
`ifdef REGISTER_SCOREBOARD_STATS_EN
    check("stall_cnt", stall_cnt, m_cnt);
`endif
  endtask

  task automatic set_in(input logic wr, input logic [4:0] dst, input logic rd,
                        input logic acc, input logic fl, input logic [4:0] rs,
                        input logic [4:0] rt, input logic ih, input logic dh);
    RegWr_ex = wr; RegDst_ex = dst; MemRead_ex = rd; MemAcc_ex = acc;
    flush_ex = fl; Rs_id = rs; Rt_id = rt; ihit = ih; dhit = dh;
  endtask

  // One clock: check at the falling edge, then advance the model across the rising edge.
  task automatic cyc();
    logic pe, st, nwait;
    @(negedge CLK);
    check_outputs();
    pe    = exp_pipe_en();
    st    = exp_stall();
    nwait = m_acc && !dhit;  // waiting next cycle iff an access is pending and not done
    @(posedge CLK);
    if (pe) begin
      w_wr = m_wr; w_dst = m_dst;
      m_wr = flush_ex ? 1'b0 : RegWr_ex;
      m_dst = flush_ex ? 5'd0 : RegDst_ex;
      m_acc = flush_ex ? 1'b0 : MemAcc_ex;
    end else if (m_acc && dhit) begin
      m_acc = 0;
    end
    m_wait = nwait;
    if ((!pe || st) && m_cnt < (1 << W) - 1) m_cnt++;
    #1;
  endtask

  // Asynchronous reset pulse starting mid-cycle; released just after a rising edge.
  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    model_clear();
    check("rst_mem_wr",  RegWr_mem,  0);
    check("rst_mem_dst", RegDst_mem, 0);
    check("rst_wb_wr",   RegWr_wb,   0);
    check("rst_wb_dst",  RegDst_wb,  0);
    check("rst_wait",    mem_wait,   0);
    check("rst_pipe_en", pipe_en,    ihit);
    check_outputs();
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    model_clear();
    #2 check_outputs();
    @(posedge CLK);
    #1 RST = 1'b0;

    // Plain ALU write flows MEM then WB.
    set_in(1, 8, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    check("alu_mem_wr", RegWr_mem, 1);
    check("alu_mem_dst", RegDst_mem, 8);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    check("alu_wb_wr", RegWr_wb, 1);
    check("alu_wb_dst", RegDst_wb, 8);

    // Load-use hazard, and the $0 exemption.
    set_in(1, 9, 1, 1, 0, 9, 0, 1, 0);
    #1 check("lu_stall", stall_id, 1);
    set_in(1, 0, 1, 1, 0, 0, 0, 1, 0);
    #1 check("lu_stall_r0", stall_id, 0);
    set_in(1, 9, 1, 1, 0, 0, 9, 1, 0);
    #1 check("lu_stall_rt", stall_id, 1);

    // Store enters MEM, three cycles of dhit=0, then completion.
    set_in(0, 7, 0, 1, 0, 0, 0, 1, 0);
    cyc();
    set_in(1, 12, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check("wait_pipe_en", pipe_en, 0);
      cyc();
      check("wait_state", mem_wait, 1);
      check("wait_frozen", RegDst_mem, 7);
    end
    dhit = 1'b1;
    #1 check("done_pipe_en", pipe_en, 1);
    cyc();
    check("done_state", mem_wait, 0);
    check("done_mem_dst", RegDst_mem, 12);

    // Flush with and without an advancing pipeline.
    set_in(1, 6, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    set_in(1, 5, 0, 0, 1, 0, 0, 1, 0);
    cyc();
    check("flush_mem_wr", RegWr_mem, 0);
    set_in(1, 6, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    set_in(1, 5, 0, 0, 1, 0, 0, 0, 0);
    cyc();
    check("flush_hold_wr", RegWr_mem, 1);
    check("flush_hold_dst", RegDst_mem, 6);

    // Reset in the middle of MEM_WAIT drops the access.
    set_in(1, 4, 1, 1, 0, 0, 0, 1, 0);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    cyc();
    check("pre_rst_wait", mem_wait, 1);
    do_reset();
    check("post_rst_pipe_en", pipe_en, 1);
    cyc();
    check("post_rst_wait", mem_wait, 0);
    check("post_rst_mem_wr", RegWr_mem, 0);

`ifdef REGISTER_SCOREBOARD_STATS_EN
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc();
    check("cnt_four", stall_cnt, 4);
    for (int i = 0; i < 10; i++) cyc();
    check("cnt_sat", stall_cnt, (1 << W) - 1);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      set_in($urandom_range(0, 9) < 7, 5'($urandom_range(0, 3)), 0,
             $urandom_range(0, 9) < 4, $urandom_range(0, 19) < 3,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 19) < 17, $urandom_range(0, 9) < 4);
      MemRead_ex = MemAcc_ex && $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 99) == 0) do_reset();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
